// File: rtl/md_sequencer.sv
// HI/LO owner for the pipeline's multiply/divide unit. Results are computed when an op is accepted.
// They are held in pending registers and committed to HI/LO after a fixed busy latency.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MdOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_MdUse,
    output logic        E_Start,
    output logic        E_Busy,
    output logic        Md_Stall,
    output logic [31:0] E_MdOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state, w_state_next;
    logic [CW-1:0]  r_cnt, w_cnt_next;
    logic [31:0]    r_hi, w_hi_next;
    logic [31:0]    r_lo, w_lo_next;
    logic [31:0]    r_pend_hi, w_pend_hi_next;
    logic [31:0]    r_pend_lo, w_pend_lo_next;
    logic           r_pend_vld, w_pend_vld_next;

    // Arithmetic datapath
    logic signed [63:0] w_a_sx, w_b_sx, w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_b_nz;
    logic               w_ovf;
    logic signed [31:0] w_sdiv_q, w_sdiv_r;
    logic [31:0]        w_quo_s, w_rem_s, w_quo_u, w_rem_u;

    assign w_a_sx   = {{32{E_A[31]}}, E_A};
    assign w_b_sx   = {{32{E_B[31]}}, E_B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};

    // A zero divisor never commits, so substitute 1 to keep the dividers well defined.
    assign w_b_nz   = (E_B == 32'd0) ? 32'd1 : E_B;
    assign w_ovf    = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
    assign w_sdiv_q = $signed(E_A) / $signed(w_b_nz);
    assign w_sdiv_r = $signed(E_A) % $signed(w_b_nz);
    assign w_quo_s  = w_ovf ? 32'h8000_0000 : w_sdiv_q;
    assign w_rem_s  = w_ovf ? 32'd0 : w_sdiv_r;
    assign w_quo_u  = E_A / w_b_nz;
    assign w_rem_u  = E_A % w_b_nz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_pend_hi  <= 32'd0;
            r_pend_lo  <= 32'd0;
            r_pend_vld <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_hi       <= w_hi_next;
            r_lo       <= w_lo_next;
            r_pend_hi  <= w_pend_hi_next;
            r_pend_lo  <= w_pend_lo_next;
            r_pend_vld <= w_pend_vld_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_hi_next       = r_hi;
        w_lo_next       = r_lo;
        w_pend_hi_next  = r_pend_hi;
        w_pend_lo_next  = r_pend_lo;
        w_pend_vld_next = r_pend_vld;
        E_Start         = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (E_MdOp)
                    OP_MULT: begin
                        E_Start         = 1'b1;
                        w_state_next    = S_RUN;
                        w_cnt_next      = CW'(MULT_CYCLES);
                        w_pend_hi_next  = w_prod_s[63:32];
                        w_pend_lo_next  = w_prod_s[31:0];
                        w_pend_vld_next = 1'b1;
                    end
                    OP_MULTU: begin
                        E_Start         = 1'b1;
                        w_state_next    = S_RUN;
                        w_cnt_next      = CW'(MULT_CYCLES);
                        w_pend_hi_next  = w_prod_u[63:32];
                        w_pend_lo_next  = w_prod_u[31:0];
                        w_pend_vld_next = 1'b1;
                    end
                    OP_DIV: begin
                        E_Start         = 1'b1;
                        w_state_next    = S_RUN;
                        w_cnt_next      = CW'(DIV_CYCLES);
                        w_pend_hi_next  = w_rem_s;
                        w_pend_lo_next  = w_quo_s;
                        w_pend_vld_next = (E_B != 32'd0);
                    end
                    OP_DIVU: begin
                        E_Start         = 1'b1;
                        w_state_next    = S_RUN;
                        w_cnt_next      = CW'(DIV_CYCLES);
                        w_pend_hi_next  = w_rem_u;
                        w_pend_lo_next  = w_quo_u;
                        w_pend_vld_next = (E_B != 32'd0);
                    end
                    OP_MTHI: w_hi_next = E_A;
                    OP_MTLO: w_lo_next = E_A;
                    default: ;
                endcase
            end
            S_RUN: begin
                // Starts and moves to HI/LO arriving here are dropped; the stall should prevent them.
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_next    = S_IDLE;
                    w_pend_vld_next = 1'b0;
                    if (r_pend_vld) begin
                        w_hi_next = r_pend_hi;
                        w_lo_next = r_pend_lo;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign E_Busy   = (r_state == S_RUN);
    assign Md_Stall = D_MdUse & (E_Start | E_Busy);
    assign E_MdOut  = (E_MdOp == OP_MFHI) ? r_hi :
                      (E_MdOp == OP_MFLO) ? r_lo : 32'd0;
    assign HI       = r_hi;
    assign LO       = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_MdOp = 4'd0;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        D_MdUse = 1'b0;
    logic        E_Start, E_Busy, Md_Stall;
    logic [31:0] E_MdOut, HI, LO;

    int total = 0;
    int bad   = 0;

    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    typedef struct {
        logic        chk_reg;
        logic        start;
        logic        busy;
        logic        stall;
        logic [31:0] mdout;
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_MdOp   (E_MdOp),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_MdUse  (D_MdUse),
        .E_Start  (E_Start),
        .E_Busy   (E_Busy),
        .Md_Stall (Md_Stall),
        .E_MdOut  (E_MdOut),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", tag, what, act, want);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared at mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.tag, "E_Start", {31'd0, E_Start}, {31'd0, e.start});
                chk(e.tag, "Md_Stall", {31'd0, Md_Stall}, {31'd0, e.stall});
                chk(e.tag, "E_MdOut", E_MdOut, e.mdout);
                if (e.chk_reg) begin
                    chk(e.tag, "E_Busy", {31'd0, E_Busy}, {31'd0, e.busy});
                    chk(e.tag, "HI", HI, e.hi);
                    chk(e.tag, "LO", LO, e.lo);
                end
            end
        end
    end

    // Starting or writing HI/LO while busy is a hazard-unit bug.
    always @(negedge clk) begin
        if (!reset && E_Busy && (E_MdOp inside {[4'd1:4'd6]})) begin
            bad++;
            $display("FAIL illegal_op_while_busy got=%0d want=none", E_MdOp);
        end
    end

    task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic duse, input logic rst, input logic s, input logic bz,
                       input logic [31:0] mo, input logic chkr, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        E_MdOp  = op;
        E_A     = a;
        E_B     = b;
        D_MdUse = duse;
        reset   = rst;
        e.chk_reg = chkr;
        e.start   = s;
        e.busy    = bz;
        e.stall   = duse & (s | bz);
        e.mdout   = mo;
        e.hi      = cur_hi;
        e.lo      = cur_lo;
        e.tag     = tag;
        exp_q.push_back(e);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic duse,
                          input logic [31:0] nh, input logic [31:0] nl, input string tag);
        $display("txn %s op=%0d a=%h b=%h expect HI=%h LO=%h", tag, op, a, b, nh, nl);
        cyc(op, a, b, duse, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, tag);
        for (int i = 0; i < n; i++)
            cyc(4'd0, 32'd0, 32'd0, duse, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, tag);
        cur_hi = nh;
        cur_lo = nl;
    endtask

    initial begin
        $display("txn reset");
        cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, "reset0");
        cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, "reset1");
        cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "idle");

        run_op(4'd1, 32'hFFFF_FFFD, 32'd5, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult");
        $display("txn mfhi/mflo after mult");
        cyc(4'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, "mfhi_mult");
        cyc(4'd8, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF1, 1'b1, "mflo_mult");

        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0, 32'h8000_0000, "div_ovf");
        run_op(4'd4, 32'hFFFF_FFFF, 32'h10, 10, 1'b0, 32'h0000_000F, 32'h0FFF_FFFF, "divu");

        $display("txn op15 treated as none");
        cyc(4'd15, 32'h1234_5678, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "op15");

        $display("txn mthi/mtlo preset");
        cyc(4'd5, 32'h1111_1111, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "mthi");
        cur_hi = 32'h1111_1111;
        cyc(4'd6, 32'h2222_2222, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "mtlo");
        cur_lo = 32'h2222_2222;
        cyc(4'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 1'b1, "mfhi_pre");

        run_op(4'd3, 32'h0000_1234, 32'd0, 10, 1'b0, 32'h1111_1111, 32'h2222_2222, "div0");
        cyc(4'd8, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2222_2222, 1'b1, "mflo_div0");

        run_op(4'd1, 32'h0001_0000, 32'h0001_0000, 5, 1'b1, 32'h0000_0001, 32'd0, "mult_stall");
        cyc(4'd7, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b1, "mfhi_stall");

        $display("txn div aborted by reset in busy cycle 4");
        cyc(4'd3, 32'd100, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, "rstdiv");
        for (int i = 0; i < 3; i++)
            cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, "rstdiv");
        cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1, "rstdiv_rst");
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "after_rst");

        run_op(4'd1, 32'd6, 32'd7, 5, 1'b0, 32'd0, 32'd42, "mult_after_rst");
        cyc(4'd8, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd42, 1'b1, "mflo_final");
        cyc(4'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, "mfhi_final");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
